// File: rtl/tomasulo_rs_pool.sv
// Tomasulo reservation-station pool: register file, register status, unified stations with
// per-op latency counters and one fixed-priority common data bus.
module tomasulo_rs_pool #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned NUM_RS   = 8,
  parameter int unsigned ADD_LAT  = 2,
  parameter int unsigned MUL_LAT  = 10,
  localparam int unsigned REG_W   = $clog2(NUM_REGS),
  localparam int unsigned TAG_W   = $clog2(NUM_RS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [1:0]        issue_op,
  input  logic [REG_W-1:0]  issue_dest,
  input  logic [REG_W-1:0]  issue_src1,
  input  logic [REG_W-1:0]  issue_src2,
  input  logic              wr_en,
  input  logic [REG_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [REG_W-1:0]  cdb_dest,
  output logic [DATA_W-1:0] cdb_data,
  output logic [TAG_W-1:0]  busy_count,
  output logic [31:0]       completed,
  output logic [31:0]       stall_cycles
);

  localparam int unsigned IDX_W   = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int unsigned MAX_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [TAG_W-1:0]  stat_q [NUM_REGS];
  logic [TAG_W-1:0]  stat_d [NUM_REGS];
  logic [NUM_RS-1:0] busy_q, busy_d;
  logic [1:0]        op_q   [NUM_RS];
  logic [1:0]        op_d   [NUM_RS];
  logic [REG_W-1:0]  dest_q [NUM_RS];
  logic [REG_W-1:0]  dest_d [NUM_RS];
  logic [DATA_W-1:0] vj_q   [NUM_RS];
  logic [DATA_W-1:0] vj_d   [NUM_RS];
  logic [DATA_W-1:0] vk_q   [NUM_RS];
  logic [DATA_W-1:0] vk_d   [NUM_RS];
  logic [TAG_W-1:0]  qj_q   [NUM_RS];
  logic [TAG_W-1:0]  qj_d   [NUM_RS];
  logic [TAG_W-1:0]  qk_q   [NUM_RS];
  logic [TAG_W-1:0]  qk_d   [NUM_RS];
  logic [CNT_W-1:0]  cnt_q  [NUM_RS];
  logic [CNT_W-1:0]  cnt_d  [NUM_RS];
  logic [31:0]       completed_q, stall_q;

  logic [IDX_W-1:0]  free_idx, win_idx;
  logic              any_done, issue_fire;
  logic [TAG_W-1:0]  s1_stat, s2_stat;

  assign issue_ready  = ~&busy_q;
  assign issue_fire   = issue_valid && issue_ready;
  assign dbg_data     = regs_q[dbg_addr];
  assign completed    = completed_q;
  assign stall_cycles = stall_q;
  assign s1_stat      = stat_q[issue_src1];
  assign s2_stat      = stat_q[issue_src2];

  // Descending scan leaves the lowest matching index in each selector.
  always_comb begin
    free_idx   = '0;
    win_idx    = '0;
    any_done   = 1'b0;
    busy_count = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      busy_count = busy_count + TAG_W'(busy_q[i]);
      if (!busy_q[i]) free_idx = IDX_W'(i);
      if (busy_q[i] && cnt_q[i] == '0) begin
        win_idx  = IDX_W'(i);
        any_done = 1'b1;
      end
    end
  end

  always_comb begin
    cdb_valid = any_done;
    cdb_tag   = '0;
    cdb_dest  = '0;
    cdb_data  = '0;
    if (any_done) begin
      cdb_tag  = TAG_W'(win_idx) + TAG_W'(1);
      cdb_dest = dest_q[win_idx];
      unique case (op_q[win_idx])
        2'd0: cdb_data = vj_q[win_idx] + vk_q[win_idx];
        2'd1: cdb_data = vj_q[win_idx] - vk_q[win_idx];
        2'd2: cdb_data = vj_q[win_idx] * vk_q[win_idx];
        2'd3: cdb_data = vj_q[win_idx] & vk_q[win_idx];
      endcase
    end
  end

  always_comb begin
    regs_d = regs_q;
    stat_d = stat_q;
    busy_d = busy_q;
    op_d   = op_q;
    dest_d = dest_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    cnt_d  = cnt_q;

    if (wr_en) regs_d[wr_addr] = wr_data;
    if (cdb_valid) begin
      regs_d[cdb_dest] = cdb_data;
      if (stat_q[cdb_dest] == cdb_tag) stat_d[cdb_dest] = '0;
      busy_d[win_idx] = 1'b0;
    end

    for (int i = 0; i < NUM_RS; i++) begin
      if (busy_q[i]) begin
        if (cdb_valid && qj_q[i] == cdb_tag) begin
          qj_d[i] = '0;
          vj_d[i] = cdb_data;
        end
        if (cdb_valid && qk_q[i] == cdb_tag) begin
          qk_d[i] = '0;
          vk_d[i] = cdb_data;
        end
        // Countdown uses pre-edge operand state, so a wakeup starts counting one edge later.
        if (qj_q[i] == '0 && qk_q[i] == '0 && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end

    if (issue_fire) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = issue_op;
      dest_d[free_idx] = issue_dest;
      cnt_d[free_idx]  = (issue_op == 2'd2) ? CNT_W'(MUL_LAT) : CNT_W'(ADD_LAT);
      vj_d[free_idx]   = '0;
      qj_d[free_idx]   = '0;
      vk_d[free_idx]   = '0;
      qk_d[free_idx]   = '0;
      if (s1_stat == '0)                          vj_d[free_idx] = regs_q[issue_src1];
      else if (cdb_valid && s1_stat == cdb_tag)   vj_d[free_idx] = cdb_data;
      else                                        qj_d[free_idx] = s1_stat;
      if (s2_stat == '0)                          vk_d[free_idx] = regs_q[issue_src2];
      else if (cdb_valid && s2_stat == cdb_tag)   vk_d[free_idx] = cdb_data;
      else                                        qk_d[free_idx] = s2_stat;
      // Placed after the CDB clear so a same-dest issue keeps its tag.
      stat_d[issue_dest] = TAG_W'(free_idx) + TAG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
        stat_q[i] <= '0;
      end
      for (int i = 0; i < NUM_RS; i++) begin
        op_q[i]   <= '0;
        dest_q[i] <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        cnt_q[i]  <= '0;
      end
      busy_q      <= '0;
      completed_q <= '0;
      stall_q     <= '0;
    end else begin
      regs_q <= regs_d;
      stat_q <= stat_d;
      busy_q <= busy_d;
      op_q   <= op_d;
      dest_q <= dest_d;
      vj_q   <= vj_d;
      vk_q   <= vk_d;
      qj_q   <= qj_d;
      qk_q   <= qk_d;
      cnt_q  <= cnt_d;
      if (cdb_valid) completed_q <= completed_q + 32'd1;
      if (issue_valid && !issue_ready) stall_q <= stall_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_tomasulo_rs_pool.sv
// Bench for tomasulo_rs_pool: timestamp-based station model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_tomasulo_rs_pool;
  localparam int NR = 8, NS = 8, ALAT = 2, MLAT = 10;

  logic        clk = 1'b0;
  logic        reset, issue_valid, issue_ready, wr_en, cdb_valid;
  logic [1:0]  issue_op;
  logic [2:0]  issue_dest, issue_src1, issue_src2, wr_addr, dbg_addr, cdb_dest;
  logic [15:0] wr_data, dbg_data, cdb_data;
  logic [3:0]  cdb_tag, busy_count;
  logic [31:0] completed, stall_cycles;

  always #5 clk = ~clk;

  tomasulo_rs_pool dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_dest(issue_dest), .issue_src1(issue_src1),
    .issue_src2(issue_src2), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_dest(cdb_dest), .cdb_data(cdb_data), .busy_count(busy_count),
    .completed(completed), .stall_cycles(stall_cycles)
  );

  // Stimulus variables, applied at the start of each step
  bit rst, iv, wen;
  int iop, idst, is1, is2, wa, da;
  logic [15:0] wd;

  // Model: each station records when it becomes done (edge number), not a counter
  typedef struct {
    bit busy; int op; int dest; logic [15:0] a; logic [15:0] b; int ta; int tb; int done_at;
  } st_t;
  st_t m_rs[NS];
  logic [15:0] m_reg[NR];
  int m_stat[NR];
  int m_edge, m_completed, m_stall;
  int n_checks = 0, n_pass = 0;

  function automatic int lat(int op);
    return (op == 2) ? MLAT : ALAT;
  endfunction

  function automatic logic [15:0] alu(int op, logic [15:0] a, logic [15:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a * b;
      default: return a & b;
    endcase
  endfunction

  function automatic int m_winner();
    for (int i = 0; i < NS; i++)
      if (m_rs[i].busy && m_rs[i].ta == 0 && m_rs[i].tb == 0 && m_rs[i].done_at <= m_edge)
        return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < NS; i++) if (!m_rs[i].busy) return i;
    return -1;
  endfunction

  function automatic int m_busy();
    int n = 0;
    for (int i = 0; i < NS; i++) if (m_rs[i].busy) n++;
    return n;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NR; i++) begin m_reg[i] = '0; m_stat[i] = 0; end
    for (int i = 0; i < NS; i++) m_rs[i] = '{0, 0, 0, 16'h0, 16'h0, 0, 0, 0};
    m_completed = 0;
    m_stall = 0;
  endtask

  task automatic m_advance();
    logic [15:0] old_reg[NR];
    int old_stat[NR];
    int w, f, nxt;
    bit fire;
    logic [15:0] data;
    if (rst) begin m_clear(); m_edge++; return; end
    old_reg = m_reg;
    old_stat = m_stat;
    w = m_winner();
    f = m_free();
    fire = iv && f >= 0;
    nxt = m_edge + 1;
    data = '0;
    if (wen) m_reg[wa] = wd;
    if (w >= 0) begin
      data = alu(m_rs[w].op, m_rs[w].a, m_rs[w].b);
      m_reg[m_rs[w].dest] = data;
      if (m_stat[m_rs[w].dest] == w + 1 && !(fire && idst == m_rs[w].dest))
        m_stat[m_rs[w].dest] = 0;
      for (int i = 0; i < NS; i++) begin
        if (m_rs[i].busy && i != w && (m_rs[i].ta == w + 1 || m_rs[i].tb == w + 1)) begin
          if (m_rs[i].ta == w + 1) begin m_rs[i].a = data; m_rs[i].ta = 0; end
          if (m_rs[i].tb == w + 1) begin m_rs[i].b = data; m_rs[i].tb = 0; end
          if (m_rs[i].ta == 0 && m_rs[i].tb == 0) m_rs[i].done_at = nxt + lat(m_rs[i].op);
        end
      end
      m_rs[w].busy = 0;
      m_completed++;
    end
    if (iv && f < 0) m_stall++;
    if (fire) begin
      m_rs[f].busy = 1; m_rs[f].op = iop; m_rs[f].dest = idst;
      m_rs[f].a = '0; m_rs[f].b = '0; m_rs[f].ta = 0; m_rs[f].tb = 0;
      if (old_stat[is1] == 0) m_rs[f].a = old_reg[is1];
      else if (w >= 0 && old_stat[is1] == w + 1) m_rs[f].a = data;
      else m_rs[f].ta = old_stat[is1];
      if (old_stat[is2] == 0) m_rs[f].b = old_reg[is2];
      else if (w >= 0 && old_stat[is2] == w + 1) m_rs[f].b = data;
      else m_rs[f].tb = old_stat[is2];
      m_rs[f].done_at = nxt + lat(iop);
      m_stat[idst] = f + 1;
    end
    m_edge = nxt;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_edge);
  endtask

  // One cycle: drive, compare every output against the model, advance the model, clock.
  task automatic step();
    int w;
    reset = rst; issue_valid = iv; issue_op = 2'(iop); issue_dest = 3'(idst);
    issue_src1 = 3'(is1); issue_src2 = 3'(is2); wr_en = wen; wr_addr = 3'(wa);
    wr_data = wd; dbg_addr = 3'(da);
    #1;
    w = m_winner();
    chk("issue_ready", 32'(issue_ready), 32'(m_free() >= 0));
    chk("cdb_valid", 32'(cdb_valid), 32'(w >= 0));
    chk("cdb_tag", 32'(cdb_tag), (w >= 0) ? w + 1 : 0);
    chk("cdb_dest", 32'(cdb_dest), (w >= 0) ? m_rs[w].dest : 0);
    chk("cdb_data", 32'(cdb_data),
        (w >= 0) ? 32'(alu(m_rs[w].op, m_rs[w].a, m_rs[w].b)) : 32'd0);
    chk("busy_count", 32'(busy_count), m_busy());
    chk("completed", completed, m_completed);
    chk("stall_cycles", stall_cycles, m_stall);
    chk("dbg_data", 32'(dbg_data), 32'(m_reg[da]));
    m_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 0; iv = 0; wen = 0;
  endtask

  task automatic idle(int n);
    set_idle();
    repeat (n) step();
  endtask

  task automatic do_reset();
    set_idle(); rst = 1; step(); rst = 0;
  endtask

  task automatic preload(int a, logic [15:0] v);
    set_idle(); wen = 1; wa = a; wd = v; step(); wen = 0;
  endtask

  task automatic do_issue(int op, int d, int s1, int s2);
    set_idle(); iv = 1; iop = op; idst = d; is1 = s1; is2 = s2; step(); iv = 0;
  endtask

  task automatic peek_reg(int a);
    da = a; dbg_addr = 3'(a); #1;
  endtask

  initial begin
    set_idle(); iop = 0; idst = 0; is1 = 0; is2 = 0; wa = 0; wd = '0; da = 0;
    m_edge = 0;
    m_clear();
    reset = 1; issue_valid = 0; wr_en = 0; issue_op = '0; issue_dest = '0;
    issue_src1 = '0; issue_src2 = '0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
    @(posedge clk); #1;

    // Reset state
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rst_busy", 32'(busy_count), 32'd0);
    chk("rst_completed", completed, 32'd0);
    for (int a = 0; a < NR; a++) begin
      peek_reg(a);
      chk("rst_dbg", 32'(dbg_data), 32'd0);
    end

    // Simple ADD: R3 = 3 + 4, broadcast two edges after issue
    do_reset(); preload(1, 16'd3); preload(2, 16'd4);
    do_issue(0, 3, 1, 2);
    idle(2);
    chk("add_valid", 32'(cdb_valid), 32'd1);
    chk("add_tag", 32'(cdb_tag), 32'd1);
    chk("add_data", 32'(cdb_data), 32'd7);
    chk("mdl_add_tag", m_winner() + 1, 32'd1);
    idle(1);
    peek_reg(3);
    chk("add_r3", 32'(dbg_data), 32'd7);
    chk("mdl_add_r3", 32'(m_reg[3]), 32'd7);

    // RAW: MUL R3=R1*R2 then ADD R4=R3+R1
    do_reset(); preload(1, 16'd3); preload(2, 16'd4);
    do_issue(2, 3, 1, 2);
    do_issue(0, 4, 3, 1);
    idle(9);
    chk("raw_mul_tag", 32'(cdb_tag), 32'd1);
    chk("raw_mul_data", 32'(cdb_data), 32'd12);
    chk("raw_busy", 32'(busy_count), 32'd2);
    idle(1);
    chk("raw_gap", 32'(cdb_valid), 32'd0);
    idle(2);
    chk("raw_add_tag", 32'(cdb_tag), 32'd2);
    chk("raw_add_data", 32'(cdb_data), 32'd15);
    chk("mdl_raw_data", 32'(alu(m_rs[1].op, m_rs[1].a, m_rs[1].b)), 32'd15);

    // Full pool with held issue_valid
    do_reset();
    set_idle(); iv = 1; iop = 2; idst = 3; is1 = 1; is2 = 2;
    repeat (8) step();
    chk("full_ready", 32'(issue_ready), 32'd0);
    chk("full_busy", 32'(busy_count), 32'd8);
    repeat (4) step();
    chk("full_ready_back", 32'(issue_ready), 32'd1);
    chk("full_stall", stall_cycles, 32'd4);
    chk("mdl_full_stall", m_stall, 32'd4);
    chk("full_completed", completed, 32'd1);
    do_reset();
    chk("midrst_cdb", 32'(cdb_valid), 32'd0);
    chk("midrst_busy", 32'(busy_count), 32'd0);

    // CDB conflict: two ADDs waiting on one MUL finish together
    do_reset(); preload(1, 16'd3); preload(2, 16'd4);
    do_issue(2, 3, 1, 2);
    do_issue(0, 4, 3, 1);
    do_issue(0, 5, 3, 2);
    idle(11);
    chk("cfl_tag_a", 32'(cdb_tag), 32'd2);
    chk("cfl_data_a", 32'(cdb_data), 32'd15);
    chk("cfl_comp_a", completed, 32'd1);
    idle(1);
    chk("cfl_tag_b", 32'(cdb_tag), 32'd3);
    chk("cfl_data_b", 32'(cdb_data), 32'd16);
    idle(1);
    chk("cfl_comp", completed, 32'd3);

    // WAW: ADD R3 then SUB R3, final value from the SUB
    do_reset(); preload(1, 16'd3); preload(2, 16'd4);
    do_issue(0, 3, 1, 2);
    do_issue(1, 3, 2, 1);
    idle(1);
    chk("waw_add_data", 32'(cdb_data), 32'd7);
    idle(1);
    chk("waw_stat", m_stat[3], 32'd2);
    chk("waw_sub_tag", 32'(cdb_tag), 32'd2);
    chk("waw_sub_data", 32'(cdb_data), 32'd1);
    idle(1);
    peek_reg(3);
    chk("waw_r3", 32'(dbg_data), 32'd1);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 599) == 0);
      iv = ($urandom_range(0, 9) < 6);
      iop = $urandom_range(0, 3);
      idst = $urandom_range(0, NR - 1);
      is1 = $urandom_range(0, NR - 1);
      is2 = $urandom_range(0, NR - 1);
      wen = ($urandom_range(0, 9) == 0);
      wa = $urandom_range(0, NR - 1);
      wd = 16'($urandom);
      da = $urandom_range(0, NR - 1);
      step();
    end
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
